// File: rtl/mca_pkg.sv
// mca_pkg: shared widths, limits and FSM encoding for the multichannel analyser front end
package mca_pkg;
  localparam int ADC_W = 14;
  localparam logic [ADC_W-1:0] ADC_MAX = 14'h3FFF;
  localparam int CNT_W = 16;
  typedef enum logic [3:0] {
    WAIT_LOW = 4'b0001,
    ARMED    = 4'b0010,
    TRACK    = 4'b0100,
    DEAD     = 4'b1000
  } state_t;
  function automatic logic [ADC_W-1:0] sub_floor(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b);
    return a > b ? a - b : '0;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones, async active-high clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector: threshold-triggered peak finder with pile-up/clip rejection and dead time
module pulse_peak_detector
  import mca_pkg::*;
#(
  parameter int DEAD_TIME = 16,
  parameter int MAX_WIDTH = 256
) (
  input  logic             CLOCK_65,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [ADC_W-1:0] threshold,
  input  logic [ADC_W-1:0] baseline,
  input  logic             enable,
  output logic [ADC_W-1:0] pulse_height,
  output logic             pulse_indicator,
  output logic [CNT_W-1:0] pulse_count,
  output logic [CNT_W-1:0] reject_count
);
  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int DW = $clog2(DEAD_TIME + 1);
  state_t           state;
  logic [ADC_W-1:0] s, peak;
  logic [WW-1:0]    width;
  logic [DW-1:0]    dcnt;
  logic             clip, above, in_track, at_limit, emit, reject;
  assign above    = s > threshold;
  assign in_track = enable && state == TRACK;
  assign at_limit = width == WW'(MAX_WIDTH - 1);
  assign emit     = in_track && !above && !clip;
  assign reject   = in_track && (above ? at_limit : clip);
  // s resets to full scale so a pulse already high at reset release must fall before arming
  always_ff @(posedge CLOCK_65 or posedge rst)
    if (rst) begin
      s               <= ADC_MAX;
      state           <= WAIT_LOW;
      peak            <= '0;
      width           <= '0;
      clip            <= 1'b0;
      dcnt            <= '0;
      pulse_height    <= '0;
      pulse_indicator <= 1'b0;
    end else begin
      s               <= adc_data;
      pulse_indicator <= emit;
      if (emit) pulse_height <= sub_floor(peak, baseline);
      if (!enable) state <= WAIT_LOW;
      else
        case (state)
          WAIT_LOW: if (!above) state <= ARMED;
          ARMED:
            if (above) begin
              state <= TRACK;
              peak  <= s;
              width <= WW'(1);
              clip  <= s == ADC_MAX;
            end
          TRACK:
            if (!above) begin
              state <= DEAD;
              dcnt  <= '0;
            end else if (at_limit) state <= WAIT_LOW;
            else begin
              peak  <= s > peak ? s : peak;
              width <= width + 1'b1;
              clip  <= clip | (s == ADC_MAX);
            end
          DEAD:
            if (dcnt == DW'(DEAD_TIME - 1)) state <= above ? WAIT_LOW : ARMED;
            else dcnt <= dcnt + 1'b1;
          default: state <= WAIT_LOW;
        endcase
    end
  sat_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk(CLOCK_65),
    .rst(rst),
    .inc(emit),
    .q  (pulse_count)
  );
  sat_counter #(.W(CNT_W)) u_reject_cnt (
    .clk(CLOCK_65),
    .rst(rst),
    .inc(reject),
    .q  (reject_count)
  );
endmodule

// File: tb/tb_pulse_peak_detector.sv
// tb_pulse_peak_detector: table-driven directed vectors plus reset and saturation sequences
module tb_pulse_peak_detector;
  logic        CLOCK_65 = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] adc_data = '0;
  logic [13:0] threshold = 14'd100;
  logic [13:0] baseline = 14'd20;
  logic        enable = 1'b1;
  logic [13:0] pulse_height;
  logic        pulse_indicator;
  logic [15:0] pulse_count, reject_count;
  logic        sc_rst = 1'b1;
  logic        sc_inc = 1'b0;
  logic [2:0]  sc_q;
  int          nvec = 0;
  int          nerr = 0;

  typedef struct {
    logic [13:0] adc;
    logic        en;
    logic [13:0] base;
    int          reps;
    logic        ind;
    logic [13:0] h;
    logic [15:0] pc;
    logic [15:0] rc;
  } vec_t;
  vec_t tbl[$];

  pulse_peak_detector #(.DEAD_TIME(16), .MAX_WIDTH(8)) dut (
    .CLOCK_65       (CLOCK_65),
    .rst            (rst),
    .adc_data       (adc_data),
    .threshold      (threshold),
    .baseline       (baseline),
    .enable         (enable),
    .pulse_height   (pulse_height),
    .pulse_indicator(pulse_indicator),
    .pulse_count    (pulse_count),
    .reject_count   (reject_count)
  );

  sat_counter #(.W(3)) u_sc (
    .clk(CLOCK_65),
    .rst(sc_rst),
    .inc(sc_inc),
    .q  (sc_q)
  );

  always #5 CLOCK_65 = ~CLOCK_65;

  task automatic step();
    @(posedge CLOCK_65);
    #1;
  endtask

  task automatic add(input int adc, input bit en, input int base, input int reps,
                     input bit ind, input int h, input int pc, input int rc);
    tbl.push_back('{adc[13:0], en, base[13:0], reps, ind, h[13:0], pc[15:0], rc[15:0]});
  endtask

  task automatic chk_outs(input string name, input logic ind, input logic [13:0] h,
                          input logic [15:0] pc, input logic [15:0] rc);
    nvec++;
    if (pulse_indicator !== ind || pulse_height !== h || pulse_count !== pc || reject_count !== rc) begin
      nerr++;
      $display("FAIL %s: got ind=%0b h=%0d pc=%0d rc=%0d, want ind=%0b h=%0d pc=%0d rc=%0d",
               name, pulse_indicator, pulse_height, pulse_count, reject_count, ind, h, pc, rc);
    end
  endtask

  task automatic chk_sc(input string name, input logic [2:0] want);
    nvec++;
    if (sc_q !== want) begin
      nerr++;
      $display("FAIL %s: got q=%0d, want q=%0d", name, sc_q, want);
    end
  endtask

  task automatic run(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      adc_data = tbl[i].adc;
      enable   = tbl[i].en;
      baseline = tbl[i].base;
      for (int r = 0; r < tbl[i].reps; r++) step();
      chk_outs($sformatf("%s_row%0d", tag, i), tbl[i].ind, tbl[i].h, tbl[i].pc, tbl[i].rc);
    end
    tbl.delete();
  endtask

  initial begin
    repeat (2) @(posedge CLOCK_65);
    #1;
    chk_outs("reset_state", 1'b0, 14'd0, 16'd0, 16'd0);
    @(negedge CLOCK_65);
    rst    = 1'b0;
    sc_rst = 1'b0;
    // basic pulse: peak 900 - baseline 20
    add(0, 1, 20, 1, 0, 0, 0, 0);
    add(150, 1, 20, 1, 0, 0, 0, 0);
    add(400, 1, 20, 1, 0, 0, 0, 0);
    add(900, 1, 20, 1, 0, 0, 0, 0);
    add(600, 1, 20, 1, 0, 0, 0, 0);
    add(50, 1, 20, 1, 0, 0, 0, 0);
    add(0, 1, 20, 1, 1, 880, 1, 0);
    add(0, 1, 20, 16, 0, 880, 1, 0);
    // clipped pulse is rejected
    add(500, 1, 20, 1, 0, 880, 1, 0);
    add(16383, 1, 20, 1, 0, 880, 1, 0);
    add(200, 1, 20, 1, 0, 880, 1, 0);
    add(0, 1, 20, 1, 0, 880, 1, 0);
    add(0, 1, 20, 1, 0, 880, 1, 1);
    add(0, 1, 20, 16, 0, 880, 1, 1);
    // pile-up: eighth above-threshold sample rejects, re-arm needs a low sample
    add(200, 1, 20, 8, 0, 880, 1, 1);
    add(200, 1, 20, 1, 0, 880, 1, 2);
    add(200, 1, 20, 3, 0, 880, 1, 2);
    add(0, 1, 20, 2, 0, 880, 1, 2);
    add(300, 1, 20, 1, 0, 880, 1, 2);
    add(0, 1, 20, 1, 0, 880, 1, 2);
    add(0, 1, 20, 1, 1, 280, 2, 2);
    add(0, 1, 20, 16, 0, 280, 2, 2);
    // seven above samples then a low one is a normal emit
    add(250, 1, 20, 7, 0, 280, 2, 2);
    add(0, 1, 20, 1, 0, 280, 2, 2);
    add(0, 1, 20, 1, 1, 230, 3, 2);
    add(0, 1, 20, 16, 0, 230, 3, 2);
    // second pulse inside dead time is ignored entirely
    add(400, 1, 20, 1, 0, 230, 3, 2);
    add(0, 1, 20, 1, 0, 230, 3, 2);
    add(0, 1, 20, 1, 1, 380, 4, 2);
    add(0, 1, 20, 3, 0, 380, 4, 2);
    add(400, 1, 20, 14, 0, 380, 4, 2);
    add(0, 1, 20, 2, 0, 380, 4, 2);
    // enable drop mid-pulse and on the falling sample
    add(300, 1, 20, 1, 0, 380, 4, 2);
    add(300, 1, 20, 1, 0, 380, 4, 2);
    add(300, 0, 20, 1, 0, 380, 4, 2);
    add(0, 0, 20, 1, 0, 380, 4, 2);
    add(0, 1, 20, 1, 0, 380, 4, 2);
    add(300, 1, 20, 1, 0, 380, 4, 2);
    add(0, 1, 20, 1, 0, 380, 4, 2);
    add(0, 0, 20, 1, 0, 380, 4, 2);
    add(0, 1, 20, 1, 0, 380, 4, 2);
    add(300, 1, 20, 1, 0, 380, 4, 2);
    add(0, 1, 20, 1, 0, 380, 4, 2);
    add(0, 1, 20, 1, 1, 280, 5, 2);
    add(0, 1, 20, 16, 0, 280, 5, 2);
    // baseline above peak floors to zero
    add(500, 1, 1000, 1, 0, 280, 5, 2);
    add(0, 1, 1000, 1, 0, 280, 5, 2);
    add(0, 1, 1000, 1, 1, 0, 6, 2);
    add(0, 1, 20, 16, 0, 0, 6, 2);
    add(300, 1, 20, 1, 0, 0, 6, 2);
    add(0, 1, 20, 1, 0, 0, 6, 2);
    add(0, 1, 20, 1, 1, 280, 7, 2);
    add(0, 1, 20, 16, 0, 280, 7, 2);
    add(300, 1, 20, 1, 0, 280, 7, 2);
    add(300, 1, 20, 1, 0, 280, 7, 2);
    run("main");
    // asynchronous reset in the middle of TRACK
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async_reset", 1'b0, 14'd0, 16'd0, 16'd0);
    @(negedge CLOCK_65);
    rst = 1'b0;
    add(300, 1, 20, 4, 0, 0, 0, 0);
    add(0, 1, 20, 2, 0, 0, 0, 0);
    add(300, 1, 20, 1, 0, 0, 0, 0);
    add(0, 1, 20, 1, 0, 0, 0, 0);
    add(0, 1, 20, 1, 1, 280, 1, 0);
    run("post_reset");
    // saturation on a narrow counter instance
    sc_inc = 1'b1;
    repeat (6) step();
    chk_sc("sat_count6", 3'd6);
    step();
    chk_sc("sat_reach_max", 3'd7);
    repeat (3) step();
    chk_sc("sat_hold_max", 3'd7);
    sc_inc = 1'b0;
    #2;
    sc_rst = 1'b1;
    #1;
    chk_sc("sat_clear", 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
